// File: rtl/random_led_pkg.sv
// Shared constants for the random-LED game: LED count, index width, UC state codes
// and the one-hot mask helper used to score button presses.
`timescale 1ns/1ps
package random_led_pkg;
  localparam int NUM_LEDS  = 11;
  localparam int LED_IDX_W = 4;

  localparam logic [3:0] INICIAL = 4'd0;
  localparam logic [3:0] GERA    = 4'd1;
  localparam logic [3:0] CARREGA = 4'd2;
  localparam logic [3:0] ESPERA  = 4'd3;
  localparam logic [3:0] ACERTO  = 4'd4;
  localparam logic [3:0] ERRO    = 4'd5;
  localparam logic [3:0] TEMPO   = 4'd6;
  localparam logic [3:0] PROXIMA = 4'd7;
  localparam logic [3:0] FIM     = 4'd8;

  // Out-of-range indices yield an all-zero mask, so they can never match a press.
  function automatic logic [NUM_LEDS-1:0] led_mask(input logic [LED_IDX_W-1:0] idx);
    logic [NUM_LEDS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_LEDS; i++) m[i] = (idx == LED_IDX_W'(i));
    return m;
  endfunction
endpackage

// File: rtl/random_led_timeout_cnt.sv
// Loadable cycle counter with clear, enable and a terminal-count flag.
// Clear has priority over load, load over increment.
`timescale 1ns/1ps
module random_led_timeout_cnt #(
  parameter int               WIDTH    = 26,
  parameter logic [WIDTH-1:0] TERMINAL = '1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)    r_count <= '0;
    else if (i_clr)  r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en)   r_count <= r_count + 1'b1;
  end

  assign o_tc = (r_count == TERMINAL);
endmodule

// File: rtl/random_led_controller_uc.sv
// Round sequencer for the random-LED game: generate, load, wait for press, score, repeat.
// RANDOM_LED_UC_TIMEOUT_EN builds the per-round timeout (TEMPO state); otherwise ESPERA waits forever.
`timescale 1ns/1ps
module random_led_controller_uc
  import random_led_pkg::*;
#(
  parameter int N_RODADAS      = 16,
  parameter int TIMEOUT_CICLOS = 50_000_000,
  parameter int W_CONT         = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 iniciar,
  input  logic [NUM_LEDS-1:0]  botoes,
  input  logic [LED_IDX_W-1:0] led_select,
  output logic                 gerar_jogada,
  output logic                 carrega_frame,
  output logic [W_CONT-1:0]    acertos,
  output logic [W_CONT-1:0]    erros,
  output logic [W_CONT-1:0]    rodada,
  output logic                 timeout,
  output logic                 pronto,
  output logic [3:0]           db_estado
);
  if (TIMEOUT_CICLOS < 2 || (1 << W_CONT) <= N_RODADAS) begin : g_bad_cfg
    $error("random_led_controller_uc: invalid TIMEOUT_CICLOS/W_CONT/N_RODADAS");
  end

  logic [3:0]          r_estado;
  logic [3:0]          w_prox;
  logic [NUM_LEDS-1:0] r_botoes_q;
  logic [NUM_LEDS-1:0] w_press;
  logic                w_hit;
  logic                w_clear;
  logic                w_tc;
  logic [W_CONT-1:0]   r_acertos;
  logic [W_CONT-1:0]   r_erros;
  logic [W_CONT-1:0]   r_rodada;

  assign w_press = botoes & ~r_botoes_q;
  assign w_hit   = (w_press == led_mask(led_select));
  assign w_clear = ((r_estado == INICIAL) || (r_estado == FIM)) && iniciar;

`ifdef RANDOM_LED_UC_TIMEOUT_EN
  localparam int W_TO = $clog2(TIMEOUT_CICLOS);

  random_led_timeout_cnt #(
    .WIDTH    (W_TO),
    .TERMINAL (W_TO'(TIMEOUT_CICLOS - 1))
  ) u_timeout_cnt (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_clr      (r_estado == CARREGA),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_en       (r_estado == ESPERA),
    .o_tc       (w_tc)
  );
`else
  assign w_tc = 1'b0;
`endif

  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      INICIAL: if (iniciar) w_prox = GERA;
      GERA:    w_prox = CARREGA;
      CARREGA: w_prox = ESPERA;
      // A press in the expiry cycle takes priority over the timeout.
      ESPERA: begin
        if (w_press != '0) w_prox = w_hit ? ACERTO : ERRO;
        else if (w_tc)     w_prox = TEMPO;
      end
      ACERTO:  w_prox = PROXIMA;
      ERRO:    w_prox = PROXIMA;
`ifdef RANDOM_LED_UC_TIMEOUT_EN
      TEMPO:   w_prox = PROXIMA;
`endif
      PROXIMA: w_prox = (r_rodada == W_CONT'(N_RODADAS)) ? FIM : GERA;
      FIM:     if (iniciar) w_prox = GERA;
      default: w_prox = INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_estado   <= INICIAL;
      r_botoes_q <= '0;
      r_acertos  <= '0;
      r_erros    <= '0;
      r_rodada   <= '0;
    end else begin
      r_estado   <= w_prox;
      r_botoes_q <= botoes;
      if (w_clear) begin
        r_acertos <= '0;
        r_erros   <= '0;
        r_rodada  <= '0;
      end else if (r_estado == ACERTO) begin
        r_acertos <= r_acertos + 1'b1;
        r_rodada  <= r_rodada + 1'b1;
      end else if ((r_estado == ERRO) || (r_estado == TEMPO)) begin
        r_erros  <= r_erros + 1'b1;
        r_rodada <= r_rodada + 1'b1;
      end
    end
  end

  assign gerar_jogada  = (r_estado == GERA);
  assign carrega_frame = (r_estado == CARREGA);
  assign timeout       = (r_estado == TEMPO);
  assign pronto        = (r_estado == FIM);
  assign db_estado     = r_estado;
  assign acertos       = r_acertos;
  assign erros         = r_erros;
  assign rodada        = r_rodada;
endmodule

// File: tb/tb_random_led_controller_uc.sv
// Directed bench for the round sequencer: N_RODADAS=3, TIMEOUT_CICLOS=8, score model kept in a queue.
`timescale 1ns/1ps
module tb_random_led_controller_uc;
  import random_led_pkg::*;

  localparam int N_ROD = 3;
  localparam int TO_C  = 8;
  localparam int WC    = 5;

  logic                 clock = 1'b0;
  logic                 reset;
  logic                 iniciar;
  logic [NUM_LEDS-1:0]  botoes;
  logic [LED_IDX_W-1:0] led_select;
  logic                 gerar_jogada;
  logic                 carrega_frame;
  logic [WC-1:0]        acertos;
  logic [WC-1:0]        erros;
  logic [WC-1:0]        rodada;
  logic                 timeout;
  logic                 pronto;
  logic [3:0]           db_estado;

  random_led_controller_uc #(
    .N_RODADAS      (N_ROD),
    .TIMEOUT_CICLOS (TO_C),
    .W_CONT         (WC)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .botoes        (botoes),
    .led_select    (led_select),
    .gerar_jogada  (gerar_jogada),
    .carrega_frame (carrega_frame),
    .acertos       (acertos),
    .erros         (erros),
    .rodada        (rodada),
    .timeout       (timeout),
    .pronto        (pronto),
    .db_estado     (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {int a; int e; int r;} score_t;
  score_t sb[$];
  int m_a, m_e, m_r;
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_exp(input bit hit);
    if (hit) m_a++;
    else     m_e++;
    m_r++;
    sb.push_back('{m_a, m_e, m_r});
  endtask

  task automatic pop_cmp(input string tag);
    score_t s;
    chk({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      s = sb.pop_front();
      chk({tag, "_acertos"}, 32'(acertos), s.a);
      chk({tag, "_erros"},   32'(erros),   s.e);
      chk({tag, "_rodada"},  32'(rodada),  s.r);
    end
  endtask

  // From INICIAL/FIM (with iniciar set) or PROXIMA: GERA, CARREGA, then first ESPERA cycle.
  task automatic round_start(input string tag);
    step(1);
    chk({tag, "_gera_state"}, 32'(db_estado), 1);
    chk({tag, "_gerar"},      32'(gerar_jogada), 1);
    chk({tag, "_carrega0"},   32'(carrega_frame), 0);
    step(1);
    chk({tag, "_gerar_once"}, 32'(gerar_jogada), 0);
    chk({tag, "_carrega"},    32'(carrega_frame), 1);
    step(1);
    chk({tag, "_espera"},     32'(db_estado), 3);
    chk({tag, "_carrega_once"}, 32'(carrega_frame), 0);
  endtask

  task automatic score_press(input string tag, input logic [NUM_LEDS-1:0] bits,
                             input logic [LED_IDX_W-1:0] sel, input bit hit);
    botoes     = bits;
    led_select = sel;
    push_exp(hit);
    step(1);
    chk({tag, "_score_state"}, 32'(db_estado), hit ? 4 : 5);
    step(1);
    chk({tag, "_proxima"}, 32'(db_estado), 7);
    pop_cmp(tag);
  endtask

  task automatic timeout_round(input string tag);
    botoes = '0;
`ifdef RANDOM_LED_UC_TIMEOUT_EN
    step(TO_C - 1);
    chk({tag, "_pre_expiry"}, 32'(db_estado), 3);
    chk({tag, "_no_to_yet"},  32'(timeout), 0);
    push_exp(1'b0);
    step(1);
    chk({tag, "_tempo"},      32'(db_estado), 6);
    chk({tag, "_to_pulse"},   32'(timeout), 1);
    step(1);
    chk({tag, "_proxima"},    32'(db_estado), 7);
    chk({tag, "_to_once"},    32'(timeout), 0);
    pop_cmp(tag);
`else
    step(3 * TO_C);
    chk({tag, "_still_wait"}, 32'(db_estado), 3);
    chk({tag, "_no_to"},      32'(timeout), 0);
    score_press({tag, "_oor"}, 11'b00000000010, 4'd12, 1'b0);
`endif
  endtask

  task automatic check_fim(input string tag, input int a, input int e);
    step(1);
    chk({tag, "_fim"},     32'(db_estado), 8);
    chk({tag, "_pronto"},  32'(pronto), 1);
    chk({tag, "_acertos"}, 32'(acertos), a);
    chk({tag, "_erros"},   32'(erros), e);
    chk({tag, "_rodada"},  32'(rodada), N_ROD);
  endtask

  task automatic restart(input string tag);
    iniciar = 1'b1;
    m_a = 0; m_e = 0; m_r = 0;
    round_start(tag);
    iniciar = 1'b0;
    chk({tag, "_pronto_low"}, 32'(pronto), 0);
    chk({tag, "_cleared"}, 32'({acertos, erros, rodada}), 0);
  endtask

  initial begin
    reset = 1'b0; iniciar = 1'b0; botoes = '0; led_select = '0;
    m_a = 0; m_e = 0; m_r = 0;
    step(2);
    chk("rst_state",   32'(db_estado), 0);
    chk("rst_outputs", 32'({gerar_jogada, carrega_frame, timeout, pronto}), 0);
    chk("rst_counts",  32'({acertos, erros, rodada}), 0);
    reset = 1'b1;
    step(1);
    chk("idle_state", 32'(db_estado), 0);

    // Game 1: held correct press, multi-bit wrong press, timeout round.
    iniciar = 1'b1;
    round_start("g1_start");
    iniciar = 1'b0;
    score_press("g1_r1", 11'b00000100000, 4'd5, 1'b1);
    round_start("g1_r2s");
    step(5);
    chk("g1_hold_state",   32'(db_estado), 3);
    chk("g1_hold_acertos", 32'(acertos), 1);
    botoes = '0;
    step(1);
    score_press("g1_r2", 11'b00010000100, 4'd2, 1'b0);
    round_start("g1_r3s");
    timeout_round("g1_r3");
    check_fim("g1", 1, 2);
    step(2);
    chk("g1_fim_hold", 32'({pronto, rodada}), {1'b1, 5'(N_ROD)});

    // Game 2: press on the expiry cycle, correct, timeout.
    restart("g2_start");
    step(TO_C - 1);
    chk("g2_edge_state", 32'(db_estado), 3);
    score_press("g2_r1", 11'b00000001000, 4'd3, 1'b1);
    chk("g2_r1_no_to", 32'(timeout), 0);
    round_start("g2_r2s");
    score_press("g2_r2", 11'b01000000000, 4'd9, 1'b1);
    round_start("g2_r3s");
    timeout_round("g2_r3");
    check_fim("g2", 2, 1);

    // Reset mid-round with a button held through release.
    restart("g3_start");
    botoes = 11'b00000010000; led_select = 4'd4;
    reset  = 1'b0;
    step(1);
    chk("mid_rst_state",   32'(db_estado), 0);
    chk("mid_rst_outputs", 32'({gerar_jogada, carrega_frame, timeout, pronto}), 0);
    chk("mid_rst_counts",  32'({acertos, erros, rodada}), 0);
    reset = 1'b1;
    step(1);
    chk("post_rst_idle", 32'(db_estado), 0);
    restart("g4_start");
    step(3);
    chk("held_no_count", 32'({db_estado, acertos, erros}), {4'd3, 10'd0});
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/random_led_controller_uc.md
Name: random_led_controller_uc

Overview:
- Control unit (UC) that sequences the random-LED datapath through a game of N_RODADAS rounds.
- Each round:
  - pulse gerar_jogada, then carrega_frame, so the datapath picks and shows one highlighted LED;
  - wait for a player button press;
  - score it against the datapath's led_select.
- Sits between the top-level game FSM (iniciar/pronto) and the datapath (gerar_jogada, carrega_frame, led_select).

Parameters:
- NUM_LEDS, 11, number of LEDs/buttons (fixed by datapath; package constant, not overridable in practice).
- N_RODADAS, 16, rounds per game (1..31).
- TIMEOUT_CICLOS, 50_000_000, clock cycles allowed in ESPERA before timeout (>=2).
- W_CONT, 5, width of score/round counters; must satisfy 2^W_CONT > N_RODADAS.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on clock edge).
- iniciar  in  1  start/restart game; level, sampled in INICIAL and FIM.
- botoes  in  NUM_LEDS  raw player buttons, already synchronised, bit i = LED i.
- led_select  in  4  index of highlighted LED from datapath; valid from the cycle after carrega_frame.
- gerar_jogada  out  1  one-cycle pulse to datapath RNG.
- carrega_frame  out  1  one-cycle pulse to datapath frame register.
- acertos  out  W_CONT  correct presses this game.
- erros  out  W_CONT  wrong presses + timeouts this game.
- rodada  out  W_CONT  completed rounds this game.
- timeout  out  1  one-cycle pulse when a round times out.
- pronto  out  1  high while in FIM.
- db_estado  out  4  current state code, for HEX debug.

Behaviour:
- Reset (reset=0 at edge):
  - state=INICIAL;
  - all outputs 0;
  - timeout counter 0;
  - botoes_q 0.
  - Reset takes precedence over every transition, including mid-round.
- Edge detect: press = botoes & ~botoes_q; botoes_q <= botoes every cycle. Holding a button produces one press.
- States and codes:
  - INICIAL 0: idle. iniciar=1 -> GERA; clear acertos/erros/rodada.
  - GERA 1: gerar_jogada=1 this cycle only -> CARREGA.
  - CARREGA 2: carrega_frame=1 this cycle only -> ESPERA; timeout counter cleared.
  - ESPERA 3: timeout counter increments each cycle.
    - press!=0 and press is one-hot with bit led_select set -> ACERTO.
    - press!=0 otherwise (wrong bit, or multiple bits) -> ERRO.
    - press==0 and counter==TIMEOUT_CICLOS-1 -> TEMPO.
    - A press in the same cycle as expiry wins (scored normally).
    - Presses during GERA/CARREGA are ignored (edge history still updates).
  - ACERTO 4: acertos+1, rodada+1 -> PROXIMA.
  - ERRO 5: erros+1, rodada+1 -> PROXIMA.
  - TEMPO 6: timeout=1, erros+1, rodada+1 -> PROXIMA.
  - PROXIMA 7: rodada==N_RODADAS -> FIM, else -> GERA.
  - FIM 8: pronto=1, counters hold. iniciar=1 -> clear counters, GERA.
- Latency:
  - iniciar to gerar_jogada: 1 cycle.
  - Press edge to counter update: 2 cycles.
  - Round turnaround (PROXIMA to next carrega_frame): 2 cycles.
- Counters never wrap: rodada <= N_RODADAS by construction, so acertos+erros <= N_RODADAS.
- led_select values >= NUM_LEDS never match; any press in that case scores ERRO.

Optional Feature:
- Macro: RANDOM_LED_UC_TIMEOUT_EN.
- Defined: timeout counter and TEMPO state are present, as described above.
- Undefined:
  - no timeout counter is built;
  - ESPERA waits indefinitely for a press;
  - TEMPO is unreachable and removed;
  - the timeout port is tied to 0.

Decomposition:
- Package random_led_pkg holds:
  - NUM_LEDS=11;
  - the state encoding constants (INICIAL..FIM, 4-bit);
  - LED_IDX_W=4.
- One natural sub-module: random_led_timeout_cnt.
  - Loadable cycle counter with clear, enable and terminal-count flag.
  - Instantiated only under RANDOM_LED_UC_TIMEOUT_EN.

Test Plan (N_RODADAS=3, TIMEOUT_CICLOS=8):
- Start: iniciar pulse from INICIAL -> gerar_jogada high exactly 1 cycle, next cycle carrega_frame high 1 cycle, db_estado=3.
- Correct press: led_select=5, botoes=11'b00000100000 held 10 cycles -> acertos=1, rodada=1, only one increment, next gerar_jogada 2 cycles later.
- Wrong/multi press: led_select=2, botoes=bits{2,7} -> erros=1, acertos unchanged.
- Timeout: no press for 8 cycles in ESPERA -> timeout pulse 1 cycle, erros+1. Repeat with press on cycle 8 -> scored as press, no timeout.
- Full game: 2 correct + 1 timeout -> FIM, pronto=1, acertos=2, erros=1, rodada=3. iniciar -> counters 0, GERA.
- Reset: reset=0 during ESPERA -> next edge state=0, all outputs 0. A held button at release does not count.
